useq_control: RTL and testbench

- Parametrised microcoded sequencer for the TTL RISC-V datapath; successor to the fixed-table control unit.
- Holds a writable main micro-op table indexed by {opcode, step} and a sub-table indexed by {func, step}, merged by OR when the SUB bit is set.
- Adds memory wait-states, trap restart, table-overflow detection and a retired-instruction counter.
- Drives the control-line word consumed by the bus, register, ALU, CSR and memory blocks.

---
 rtl/useq_control.sv | 141 ++++++++++++++
 tb/tb_useq_control.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/useq_control.sv
// useq_control: microcoded sequencer for the TTL RISC-V datapath.
// A writable main micro-op table indexed by {opcode, step} supplies the control
// word for each micro-step; a sub-table indexed by {func, step} is OR-merged in
// when the word's SUB field is set. Step 0 always issues the fixed fetch word.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   opcode, func        decoded opcode / func3 used to index the tables
//   cond                branch comparison result for COND steps
//   mem_ready           memory handshake; low stalls WAIT steps
//   trap                abandon the current instruction, return to step 0
//   uop_we/sel/addr/data  table write port ({row, step} addressing)
//   ctrl                registered control word (updated on falling edge)
//   step                current micro-step (updated on rising edge)
//   instret             retired-instruction counter
//   seq_err             sticky step-overflow flag
module useq_control #(
    parameter int unsigned CW         = 32,
    parameter int unsigned OPW        = 5,
    parameter int unsigned FW         = 3,
    parameter int unsigned STEPS      = 8,
    parameter logic [CW-1:0] FETCH_WORD = CW'(32'h8000_0045),
    localparam int unsigned SW        = $clog2(STEPS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [OPW-1:0]    opcode,
    input  logic [FW-1:0]     func,
    input  logic              cond,
    input  logic              mem_ready,
    input  logic              trap,
    input  logic              uop_we,
    input  logic              uop_sel,
    input  logic [OPW+SW-1:0] uop_addr,
    input  logic [CW-1:0]     uop_data,
    output logic [CW-1:0]     ctrl,
    output logic [SW-1:0]     step,
    output logic [63:0]       instret,
    output logic              seq_err
);

    localparam int unsigned MAIN_DEPTH = 1 << (OPW + SW);
    localparam int unsigned SUB_DEPTH  = 1 << (FW + SW);

    // Sequencer field positions at the top of every control word
    localparam int unsigned B_INC  = CW - 1;
    localparam int unsigned B_RST  = CW - 2;
    localparam int unsigned B_COND = CW - 3;
    localparam int unsigned B_SUB  = CW - 4;
    localparam int unsigned B_WAIT = CW - 5;

    localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

    logic [CW-1:0] main_tbl [MAIN_DEPTH];
    logic [CW-1:0] sub_tbl  [SUB_DEPTH];

    logic [CW-1:0] main_word_c;
    logic [CW-1:0] sub_word_c;
    logic [CW-1:0] ctrl_next_c;
    logic [SW-1:0] step_next_c;
    logic          overflow_c;
    logic          retire_c;

    logic [SW-1:0]  wr_step;
    logic [OPW-1:0] wr_row;

    assign wr_step = uop_addr[SW-1:0];
    assign wr_row  = uop_addr[OPW+SW-1:SW];

    // Table write port; step-0 entries do not exist, so those writes are dropped
    always_ff @(posedge clk) begin
        if (uop_we && (wr_step != '0)) begin
            if (uop_sel) begin
                sub_tbl[{wr_row[FW-1:0], wr_step}] <= uop_data;
            end else begin
                main_tbl[uop_addr] <= uop_data;
            end
        end
    end

    // Control word lookup with optional sub-table merge
    always_comb begin
        main_word_c = main_tbl[{opcode, step}];
        sub_word_c  = sub_tbl[{func, step}];
        ctrl_next_c = FETCH_WORD;
        if (step != '0) begin
            ctrl_next_c = main_word_c | (main_word_c[B_SUB] ? sub_word_c : '0);
        end
    end

    // ctrl launches on the falling edge so it is settled for the next rising edge
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl <= '0;
        end else begin
            ctrl <= ctrl_next_c;
        end
    end

    // Next-step selection in priority order: trap, stall, cond, rst, inc, hold
    always_comb begin
        step_next_c = step;
        overflow_c  = 1'b0;
        if (trap) begin
            step_next_c = '0;
        end else if (ctrl[B_WAIT] && !mem_ready) begin
            step_next_c = step;
        end else if (ctrl[B_COND]) begin
            if (cond) begin
                step_next_c = step + SW'(1);
                overflow_c  = (step == LAST_STEP);
            end else begin
                step_next_c = '0;
            end
        end else if (ctrl[B_RST]) begin
            step_next_c = '0;
        end else if (ctrl[B_INC]) begin
            step_next_c = step + SW'(1);
            overflow_c  = (step == LAST_STEP);
        end
        retire_c = (step != '0) && (step_next_c == '0) && !trap;
    end

    // Step register, retire counter and sticky overflow flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step    <= '0;
            instret <= '0;
            seq_err <= 1'b0;
        end else begin
            step <= step_next_c;
            if (retire_c) begin
                instret <= instret + 64'd1;
            end
            if (overflow_c) begin
                seq_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_useq_control.sv
// Bench for useq_control: directed scenarios followed by random traffic, all
// compared against a cycle-level reference model of the sequencing rules.
module tb_useq_control;

    localparam logic [31:0] F_INC  = 32'h8000_0000;
    localparam logic [31:0] F_RST  = 32'h4000_0000;
    localparam logic [31:0] F_COND = 32'h2000_0000;
    localparam logic [31:0] F_SUB  = 32'h1000_0000;
    localparam logic [31:0] F_WAIT = 32'h0800_0000;
    localparam logic [31:0] FETCH  = 32'h8000_0045;
    localparam logic [31:0] LOWMSK = 32'h07FF_FFFF;

    logic        clk;
    logic        reset_n;
    logic [4:0]  opcode;
    logic [2:0]  func;
    logic        cond;
    logic        mem_ready;
    logic        trap;
    logic        uop_we;
    logic        uop_sel;
    logic [7:0]  uop_addr;
    logic [31:0] uop_data;
    logic [31:0] ctrl;
    logic [2:0]  step;
    logic [63:0] instret;
    logic        seq_err;

    int tests;
    int fails;

    // Reference model state
    logic [31:0] mm [32][8];
    logic [31:0] sm [8][8];
    int          m_step;
    logic [31:0] m_ctrl;
    logic [63:0] m_instret;
    logic        m_seq_err;

    useq_control dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .opcode    (opcode),
        .func      (func),
        .cond      (cond),
        .mem_ready (mem_ready),
        .trap      (trap),
        .uop_we    (uop_we),
        .uop_sel   (uop_sel),
        .uop_addr  (uop_addr),
        .uop_data  (uop_data),
        .ctrl      (ctrl),
        .step      (step),
        .instret   (instret),
        .seq_err   (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("step", 64'(step), 64'(m_step));
        chk("ctrl", 64'(ctrl), 64'(m_ctrl));
        chk("instret", instret, m_instret);
        chk("seq_err", 64'(seq_err), 64'(m_seq_err));
    endtask

    // One full clock: model rising-edge rules, then falling-edge word lookup, then compare
    task automatic tick();
        int  ns;
        bit  ov;
        int  a_row;
        int  a_st;
        @(posedge clk);
        ov = 0;
        if (trap) ns = 0;
        else if (m_ctrl[27] && !mem_ready) ns = m_step;
        else if (m_ctrl[29]) begin
            if (cond) begin
                ns = (m_step + 1) % 8;
                ov = (m_step == 7);
            end else ns = 0;
        end
        else if (m_ctrl[30]) ns = 0;
        else if (m_ctrl[31]) begin
            ns = (m_step + 1) % 8;
            ov = (m_step == 7);
        end
        else ns = m_step;
        if (m_step != 0 && ns == 0 && !trap) m_instret = m_instret + 64'd1;
        if (ov) m_seq_err = 1'b1;
        a_row = int'(uop_addr) / 8;
        a_st  = int'(uop_addr) % 8;
        if (uop_we && a_st != 0) begin
            if (uop_sel) sm[a_row % 8][a_st] = uop_data;
            else         mm[a_row][a_st]     = uop_data;
        end
        m_step = ns;
        @(negedge clk);
        if (m_step == 0) m_ctrl = FETCH;
        else begin
            m_ctrl = mm[opcode][m_step];
            if (m_ctrl[28]) m_ctrl = m_ctrl | sm[func][m_step];
        end
        #1;
        chk_all();
    endtask

    task automatic wr(input bit sel, input int row, input int st, input logic [31:0] d);
        uop_we   = 1'b1;
        uop_sel  = sel;
        uop_addr = 8'((row << 3) | st);
        uop_data = d;
        tick();
        uop_we   = 1'b0;
    endtask

    task automatic model_reset();
        m_step    = 0;
        m_ctrl    = '0;
        m_instret = '0;
        m_seq_err = 1'b0;
    endtask

    initial begin
        logic [63:0] saved;
        tests = 0;
        fails = 0;
        reset_n = 1'b0; opcode = '0; func = '0; cond = 1'b0; mem_ready = 1'b1;
        trap = 1'b0; uop_we = 1'b0; uop_sel = 1'b0; uop_addr = '0; uop_data = '0;
        model_reset();
        #2;
        chk("reset_step", 64'(step), 64'd0);
        chk("reset_ctrl", 64'(ctrl), 64'd0);
        chk("reset_instret", instret, 64'd0);
        chk("reset_seq_err", 64'(seq_err), 64'd0);

        // Release reset, then load tables while trap pins the sequencer at step 0
        @(negedge clk); #2;
        reset_n = 1'b1;
        trap = 1'b1;
        tick();
        chk("first_fetch", 64'(ctrl), 64'(FETCH));
        for (int r = 0; r < 32; r++)
            for (int s = 1; s < 8; s++)
                wr(1'b0, r, s, F_RST | ($urandom & LOWMSK));
        for (int r = 0; r < 8; r++)
            for (int s = 1; s < 8; s++)
                wr(1'b1, r, s, $urandom & LOWMSK);
        wr(1'b0, 13, 1, F_RST | 32'h209);
        wr(1'b0, 2, 1, F_INC);
        wr(1'b0, 2, 2, F_INC);
        wr(1'b0, 2, 3, F_WAIT | F_INC | 32'h33);
        wr(1'b0, 2, 4, F_RST);
        wr(1'b0, 3, 1, F_INC);
        wr(1'b0, 3, 2, F_INC);
        wr(1'b0, 3, 3, F_COND | F_INC);
        wr(1'b0, 3, 4, F_RST);
        wr(1'b0, 28, 1, F_SUB);
        wr(1'b0, 28, 2, F_RST);
        wr(1'b1, 1, 1, F_INC | 32'h0080_1000);
        for (int s = 1; s < 8; s++) wr(1'b0, 4, s, F_INC | 32'(s));
        wr(1'b0, 13, 0, 32'hDEAD_BEEF);
        trap = 1'b0;

        // Two-step instruction ending in RST
        opcode = 5'b01101;
        tick();
        chk("rst_word", 64'(ctrl), 64'h4000_0209);
        tick();
        chk("rst_back_to_fetch", 64'(ctrl), 64'(FETCH));
        chk("rst_instret", instret, 64'd1);

        // Memory wait-state stall at step 3
        opcode = 5'd2;
        mem_ready = 1'b0;
        repeat (3) tick();
        chk("wait_at3", 64'(step), 64'd3);
        repeat (4) begin
            tick();
            chk("wait_hold_step", 64'(step), 64'd3);
            chk("wait_hold_ctrl", 64'(ctrl), 64'(F_WAIT | F_INC | 32'h33));
        end
        wr(1'b0, 2, 3, F_WAIT | F_INC | 32'h44);
        chk("write_in_stall", 64'(ctrl), 64'(F_WAIT | F_INC | 32'h44));
        mem_ready = 1'b1;
        tick();
        chk("wait_release", 64'(step), 64'd4);
        tick();

        // Branch taken then not taken
        opcode = 5'd3;
        cond = 1'b1;
        repeat (4) tick();
        chk("cond_taken", 64'(step), 64'd4);
        tick();
        cond = 1'b0;
        saved = instret;
        repeat (4) tick();
        chk("cond_not_taken", 64'(step), 64'd0);
        chk("cond_retire", instret, saved + 64'd1);

        // Sub-table merge
        opcode = 5'b11100;
        func = 3'b001;
        tick();
        chk("sub_merge", 64'(ctrl), 64'h9080_1000);
        repeat (2) tick();

        // Overflow: INC at last step wraps and sets sticky flag
        opcode = 5'd4;
        repeat (8) tick();
        chk("ovf_step", 64'(step), 64'd0);
        chk("ovf_flag", 64'(seq_err), 64'd1);
        repeat (3) tick();
        chk("ovf_sticky", 64'(seq_err), 64'd1);
        repeat (5) tick();

        // Trap during a stall
        opcode = 5'd2;
        mem_ready = 1'b0;
        repeat (4) tick();
        saved = instret;
        trap = 1'b1;
        tick();
        chk("trap_step", 64'(step), 64'd0);
        chk("trap_instret", instret, saved);
        trap = 1'b0;

        // Asynchronous reset mid-step 3
        repeat (3) tick();
        chk("pre_reset_step", 64'(step), 64'd3);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_step", 64'(step), 64'd0);
        chk("async_rst_ctrl", 64'(ctrl), 64'd0);
        chk("async_rst_instret", instret, 64'd0);
        chk("async_rst_seq_err", 64'(seq_err), 64'd0);
        @(negedge clk); #1;
        reset_n = 1'b1;
        mem_ready = 1'b1;
        tick();
        chk("post_reset_fetch", 64'(ctrl), 64'(FETCH));

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            if (m_step == 0 && ($urandom % 2) == 0) begin
                opcode = 5'($urandom);
                func   = 3'($urandom);
            end
            cond      = 1'($urandom);
            mem_ready = (($urandom % 4) != 0);
            trap      = (($urandom % 16) == 0);
            uop_we    = (($urandom % 8) == 0);
            uop_sel   = 1'($urandom);
            uop_addr  = 8'($urandom);
            uop_data  = $urandom;
            tick();
        end
        uop_we = 1'b0;
        trap = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
